// File: rtl/weight_sram_loader.sv
// weight_sram_loader: streams host words into four weight/BN SRAM write ports in order (optional checksum via WLOAD_CHECKSUM_EN)
module weight_sram_loader #(
    parameter int weight_width = 32,
    parameter int addr_width1  = 12,
    parameter int addr_width2  = 10,
    parameter int bn_width     = 16,
    parameter int addr_width3  = 8,
    parameter int len1         = 4096,
    parameter int len2         = 4096,
    parameter int len3         = 1024,
    parameter int len4         = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [weight_width-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    cs1_wr,
    output logic                    oe1_wr,
    output logic                    we1_wr,
    output logic [addr_width1-1:0]  addr1_wr,
    output logic [weight_width-1:0] data1_wr,
    output logic                    cs2_wr,
    output logic                    oe2_wr,
    output logic                    we2_wr,
    output logic [addr_width1-1:0]  addr2_wr,
    output logic [weight_width-1:0] data2_wr,
    output logic                    cs3_wr,
    output logic                    oe3_wr,
    output logic                    we3_wr,
    output logic [addr_width2-1:0]  addr3_wr,
    output logic [weight_width-1:0] data3_wr,
    output logic                    cs4_wr,
    output logic                    oe4_wr,
    output logic                    we4_wr,
    output logic [addr_width3-1:0]  addr4_wr,
    output logic [bn_width-1:0]     data4_wr
`ifdef WLOAD_CHECKSUM_EN
    ,
    output logic [31:0]             checksum,
    output logic                    checksum_valid
`endif
);
    localparam int AM12 = addr_width1 > addr_width2 ? addr_width1 : addr_width2;
    localparam int CW   = (AM12 > addr_width3 ? AM12 : addr_width3) + 1;

    typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, LOAD3, LOAD4, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           len_m1;
    logic [3:0]              sel;
    logic [3:0]              wr_q;
    logic                    accept, last;
    logic [addr_width1-1:0]  addr1_q, addr2_q;
    logic [addr_width2-1:0]  addr3_q;
    logic [addr_width3-1:0]  addr4_q;
    logic [weight_width-1:0] data1_q, data2_q, data3_q;
    logic [bn_width-1:0]     data4_q;

    assign len_m1 = state_q == LOAD1 ? CW'(len1 - 1) :
                    state_q == LOAD2 ? CW'(len2 - 1) :
                    state_q == LOAD3 ? CW'(len3 - 1) : CW'(len4 - 1);
    assign last   = cnt_q == len_m1;
    assign accept = in_valid && in_ready;

    // state and word counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: start only from IDLE, abort only while loading, bank advance on the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            state_d = start ? LOAD1 : IDLE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (in_valid) begin
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            state_d = !last ? state_q : (state_q == LOAD4 ? DONE : state_t'(state_q + 3'd1));
        end
    end

    // outputs decoded from state so banks follow each other without a bubble
    always_comb begin
        sel      = {state_q == LOAD4, state_q == LOAD3, state_q == LOAD2, state_q == LOAD1};
        in_ready = |sel && !abort;
        busy     = state_q != IDLE;
        done     = state_q == DONE;
    end

    // write ports: one-cycle strobe per accept, address/data held between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            addr1_q <= '0;
            addr2_q <= '0;
            addr3_q <= '0;
            addr4_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
            data3_q <= '0;
            data4_q <= '0;
        end else begin
            wr_q <= sel & {4{accept}};
            if (accept && sel[0]) begin
                addr1_q <= cnt_q[addr_width1-1:0];
                data1_q <= in_data;
            end
            if (accept && sel[1]) begin
                addr2_q <= cnt_q[addr_width1-1:0];
                data2_q <= in_data;
            end
            if (accept && sel[2]) begin
                addr3_q <= cnt_q[addr_width2-1:0];
                data3_q <= in_data;
            end
            if (accept && sel[3]) begin
                addr4_q <= cnt_q[addr_width3-1:0];
                data4_q <= in_data[bn_width-1:0];
            end
        end
    end

    assign {cs1_wr, we1_wr, oe1_wr, addr1_wr, data1_wr} = {wr_q[0], wr_q[0], 1'b0, addr1_q, data1_q};
    assign {cs2_wr, we2_wr, oe2_wr, addr2_wr, data2_wr} = {wr_q[1], wr_q[1], 1'b0, addr2_q, data2_q};
    assign {cs3_wr, we3_wr, oe3_wr, addr3_wr, data3_wr} = {wr_q[2], wr_q[2], 1'b0, addr3_q, data3_q};
    assign {cs4_wr, we4_wr, oe4_wr, addr4_wr, data4_wr} = {wr_q[3], wr_q[3], 1'b0, addr4_q, data4_q};

`ifdef WLOAD_CHECKSUM_EN
    logic [31:0] sum_q;
    logic        sum_valid_q;

    // running sum of accepted words; valid from done until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            if (accept)
                sum_q <= sum_q + 32'(in_data);
            if (done)
                sum_valid_q <= 1'b1;
        end
    end

    assign checksum       = sum_q;
    assign checksum_valid = sum_valid_q | done;
`endif
endmodule

// File: tb/tb_weight_sram_loader.sv
// tb_weight_sram_loader: directed vector bench for weight_sram_loader with small bank lengths
module tb_weight_sram_loader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, busy, done;
    logic        cs1_wr, oe1_wr, we1_wr, cs2_wr, oe2_wr, we2_wr;
    logic        cs3_wr, oe3_wr, we3_wr, cs4_wr, oe4_wr, we4_wr;
    logic [11:0] addr1_wr, addr2_wr;
    logic [9:0]  addr3_wr;
    logic [7:0]  addr4_wr;
    logic [31:0] data1_wr, data2_wr, data3_wr;
    logic [15:0] data4_wr;
`ifdef WLOAD_CHECKSUM_EN
    logic [31:0] checksum;
    logic        checksum_valid;
`endif

    always #5 clk = ~clk;

    weight_sram_loader #(.len1(4), .len2(4), .len3(2), .len4(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .done(done),
        .cs1_wr(cs1_wr), .oe1_wr(oe1_wr), .we1_wr(we1_wr), .addr1_wr(addr1_wr), .data1_wr(data1_wr),
        .cs2_wr(cs2_wr), .oe2_wr(oe2_wr), .we2_wr(we2_wr), .addr2_wr(addr2_wr), .data2_wr(data2_wr),
        .cs3_wr(cs3_wr), .oe3_wr(oe3_wr), .we3_wr(we3_wr), .addr3_wr(addr3_wr), .data3_wr(data3_wr),
        .cs4_wr(cs4_wr), .oe4_wr(oe4_wr), .we4_wr(we4_wr), .addr4_wr(addr4_wr), .data4_wr(data4_wr)
`ifdef WLOAD_CHECKSUM_EN
        , .checksum(checksum), .checksum_valid(checksum_valid)
`endif
    );

    logic [11:0] o;
    assign o = {in_ready, busy, done, cs4_wr, cs3_wr, cs2_wr, cs1_wr,
                we4_wr, we3_wr, we2_wr, we1_wr, oe1_wr | oe2_wr | oe3_wr | oe4_wr};

    int ncmp = 0, nfail = 0;
    int ln = 0, multi = 0, dcnt = 0;
    int          lbank [128];
    logic [31:0] laddr [128];
    logic [31:0] ldata [128];

    function void push(input int b, input logic [31:0] a, input logic [31:0] d);
        if (ln < 128) begin
            lbank[ln] = b;
            laddr[ln] = a;
            ldata[ln] = d;
        end
        ln++;
    endfunction

    // SRAM-side observer: logs every write captured on a rising edge
    always @(posedge clk) begin
        if (cs1_wr && we1_wr) push(1, 32'(addr1_wr), data1_wr);
        if (cs2_wr && we2_wr) push(2, 32'(addr2_wr), data2_wr);
        if (cs3_wr && we3_wr) push(3, 32'(addr3_wr), data3_wr);
        if (cs4_wr && we4_wr) push(4, 32'(addr4_wr), 32'(data4_wr));
        if ($countones({cs1_wr, cs2_wr, cs3_wr, cs4_wr}) > 1) multi++;
        if (done) dcnt++;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic a, input logic [31:0] d);
        @(negedge clk);
        start = s; in_valid = v; abort = a; in_data = d;
        #1;
    endtask

    function automatic logic [3:0] bm(input int j);
        return j < 4 ? 4'b0001 : j < 8 ? 4'b0010 : j < 10 ? 4'b0100 : 4'b1000;
    endfunction
    function automatic int bnk(input int j);
        return j < 4 ? 1 : j < 8 ? 2 : j < 10 ? 3 : 4;
    endfunction
    function automatic int adr(input int j);
        return j < 4 ? j : j < 8 ? j - 4 : j < 10 ? j - 8 : j - 10;
    endfunction
    function automatic logic [11:0] ex(input logic r, input logic b, input logic d, input logic [3:0] m);
        return {r, b, d, m, m, 1'b0};
    endfunction

    task automatic chk_log(input string nm, input int idx, input int b, input int a, input logic [31:0] d);
        chk(nm, {8'(lbank[idx]), 24'(laddr[idx]), ldata[idx]}, {8'(b), 24'(a), d});
    endtask

    function automatic logic [31:0] bdat(input int j, input logic [31:0] w);
        return bnk(j) == 4 ? (w & 32'h0000_FFFF) : w;
    endfunction

    typedef struct {
        logic        s, v, a;
        logic [31:0] d;
        logic [11:0] e;
    } vec_t;

    vec_t tv[$];
    int   s0, d0;

    initial begin
        // back-to-back load, then the same load with in_valid toggling
        tv.push_back('{1'b1, 1'b0, 1'b0, 32'h0, ex(0, 0, 0, 4'b0)});
        for (int j = 0; j < 12; j++)
            tv.push_back('{1'b0, 1'b1, 1'b0, 32'h100 + 32'(j), ex(1, 1, 0, j == 0 ? 4'b0 : bm(j - 1))});
        tv.push_back('{1'b0, 1'b0, 1'b0, 32'h0, ex(0, 1, 1, bm(11))});
        tv.push_back('{1'b0, 1'b0, 1'b0, 32'h0, ex(0, 0, 0, 4'b0)});
        tv.push_back('{1'b1, 1'b0, 1'b0, 32'h0, ex(0, 0, 0, 4'b0)});
        for (int k = 1; k < 24; k++)
            tv.push_back('{1'b0, k[0], 1'b0, 32'hABCD_0300 + 32'((k - 1) / 2),
                           ex(1, 1, 0, (k >= 2 && !k[0]) ? bm((k - 2) / 2) : 4'b0)});
        tv.push_back('{1'b0, 1'b0, 1'b0, 32'h0, ex(0, 1, 1, bm(11))});
        tv.push_back('{1'b0, 1'b0, 1'b0, 32'h0, ex(0, 0, 0, 4'b0)});

        #12;
        chk("reset_ctl", {o, addr1_wr, addr2_wr, addr3_wr, addr4_wr}, '0);
        chk("reset_data", {data1_wr, data2_wr, data3_wr, data4_wr}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            cyc(tv[i].s, tv[i].v, tv[i].a, tv[i].d);
            chk($sformatf("vec%0d", i), o, tv[i].e);
        end
        for (int j = 0; j < 12; j++) begin
            chk_log($sformatf("b2b_w%0d", j), j, bnk(j), adr(j), bdat(j, 32'h100 + 32'(j)));
            chk_log($sformatf("tog_w%0d", j), 12 + j, bnk(j), adr(j), bdat(j, 32'hABCD_0300 + 32'(j)));
        end
        chk("done_cnt_12", 128'(dcnt), 128'd2);

        // abort after five accepts, then restart from bank 1 address 0
        s0 = ln; d0 = dcnt;
        cyc(1, 0, 0, 0);
        for (int j = 0; j < 5; j++) cyc(0, 1, 0, 32'h400 + 32'(j));
        cyc(0, 1, 1, 32'h4FF);
        chk("abort_cycle", o, ex(0, 1, 0, 4'b0010));
        cyc(0, 1, 0, 32'h4FF);
        chk("abort_idle", o, ex(0, 0, 0, 4'b0));
        chk("abort_nwr", 128'(ln - s0), 128'd5);
        chk_log("abort_b2", s0 + 4, 2, 0, 32'h404);
        chk("abort_nodone", 128'(dcnt - d0), 128'd0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 32'h500);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk_log("restart_b1", s0 + 5, 1, 0, 32'h500);
        chk("restart_nwr", 128'(ln - s0), 128'd6);

        // start during LOAD2 is ignored
        s0 = ln; d0 = dcnt;
        cyc(1, 0, 0, 0);
        for (int j = 0; j < 12; j++) cyc(j == 5, 1, 0, 32'h600 + 32'(j));
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int j = 0; j < 12; j++)
            chk_log($sformatf("st2_w%0d", j), s0 + j, bnk(j), adr(j), bdat(j, 32'h600 + 32'(j)));
        chk("st2_nwr", 128'(ln - s0), 128'd12);
        chk("st2_done", 128'(dcnt - d0), 128'd1);

        // reset asserted during LOAD3 drops the in-flight write
        s0 = ln;
        cyc(1, 0, 0, 0);
        for (int j = 0; j < 9; j++) cyc(0, 1, 0, 32'h700 + 32'(j));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", o, ex(0, 0, 0, 4'b0));
        chk("rst_nwr", 128'(ln - s0), 128'd8);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 0, 32'h7FF);
        chk("rst_idle", o, ex(0, 0, 0, 4'b0));
        cyc(0, 1, 0, 32'h7FF);
        chk("rst_nwr2", 128'(ln - s0), 128'd8);

`ifdef WLOAD_CHECKSUM_EN
        cyc(1, 0, 0, 0);
        for (int j = 0; j < 12; j++) cyc(0, 1, 0, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0);
        chk("csum_done", {checksum, checksum_valid, done}, {32'hFFFF_FFF4, 1'b1, 1'b1});
        cyc(0, 0, 0, 0);
        chk("csum_hold", {checksum, checksum_valid}, {32'hFFFF_FFF4, 1'b1});
`endif

        chk("one_bank", 128'(multi), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/weight_sram_loader.md
Name: weight_sram_loader

Overview:
- Write-side master for the four-bank weight/BN SRAM group.
- Accepts one stream of 32-bit words from the host/DMA over valid/ready.
- Writes the words in order into bank 1 (conv weights), bank 2 (conv weights), bank 3 (FC weights) and bank 4 (BN params), driving each bank's write port.
- Pulses done when all four banks are loaded; the compute datapath then owns the read ports.

Parameters:
- weight_width, 32, word width of the input stream and of banks 1-3.
- addr_width1, 12, address width of banks 1 and 2.
- addr_width2, 10, address width of bank 3.
- bn_width, 16, data width of bank 4.
- addr_width3, 8, address width of bank 4.
- len1, 4096, words written to bank 1 (1..2^addr_width1).
- len2, 4096, words written to bank 2 (1..2^addr_width1).
- len3, 1024, words written to bank 3 (1..2^addr_width2).
- len4, 256, words written to bank 4 (1..2^addr_width3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle load request; honoured only in IDLE.
- abort  input  1  synchronous abort of a load in progress.
- in_data  input  weight_width  stream word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a word this cycle.
- busy  output  1  high from the first LOAD1 cycle through DONE.
- done  output  1  one-cycle completion pulse.
- cs1_wr/oe1_wr/we1_wr  output  1 each  bank 1 write-port chip select / output enable / write enable.
- addr1_wr  output  addr_width1  bank 1 write address.
- data1_wr  output  weight_width  bank 1 write data.
- cs2_wr/oe2_wr/we2_wr, addr2_wr, data2_wr  output  1/1/1, addr_width1, weight_width  bank 2 write port.
- cs3_wr/oe3_wr/we3_wr, addr3_wr, data3_wr  output  1/1/1, addr_width2, weight_width  bank 3 write port.
- cs4_wr/oe4_wr/we4_wr, addr4_wr, data4_wr  output  1/1/1, addr_width3, bn_width  bank 4 write port.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- All control is active-high. oeN_wr is tied 0.
- States: IDLE, LOAD1, LOAD2, LOAD3, LOAD4, DONE.
- Reset values: state IDLE; word counter 0; in_ready 0, busy 0, done 0; all csN_wr/weN_wr 0; all addr/data outputs 0.
- IDLE -> LOAD1 on start. start in any other state is ignored.
- in_ready = 1 exactly when the state is LOADn and abort is low. It is decoded from state, so there is no bubble between banks.
- Accept = in_valid && in_ready.
- Accept in LOADn: the next cycle drives csN_wr=1, weN_wr=1, addrN_wr=counter, dataN_wr=in_data. Write latency is 1 cycle; the SRAM captures on the following edge.
- Bank 4 takes in_data[bn_width-1:0]; the upper bits are discarded.
- Cycles without an accept drive all cs/we low. Address and data hold their last values.
- Only one bank's cs/we is ever high in a given cycle.
- Counter increments per accept. On the accept with counter==lenN-1, the counter clears to 0 and the state goes to LOAD(N+1); from LOAD4 it goes to DONE.
- Counter width is max(addr_width1, addr_width2, addr_width3) + 1. Addresses never wrap within a bank.
- in_valid low stalls the load indefinitely; state and counter hold.
- DONE lasts one cycle: done=1, in_ready=0, then IDLE. The final bank-4 write is issued in the DONE cycle.
- abort in any LOADn state: no accept that cycle, state -> IDLE, counter -> 0, no done. Banks keep their partial contents. abort in IDLE/DONE is ignored.
- A write already issued in the abort cycle still completes.
- rst_n low mid-load: all outputs return to reset values immediately, including cs/we, so the in-flight write is dropped.

Optional Feature:
- Macro WLOAD_CHECKSUM_EN.
- When defined: adds output checksum [31:0] and output checksum_valid 1.
  - checksum clears on start and adds every accepted word (full weight_width, mod 2^32).
  - checksum_valid rises with done and holds until the next start or reset.
- When undefined: neither port nor accumulator exists; all other behaviour is identical.

Test Plan:
- len1=4,len2=4,len3=2,len4=2; start, then 12 back-to-back words 0x100..0x10B -> bank1 addr0-3 get 0x100-0x103, bank2 gets 0x104-0x107, bank3 gets 0x108-0x109, bank4 gets 0x010A,0x010B; done pulses once, 1 cycle after the last accept.
- Same config with in_valid toggling 1/0 every cycle -> identical bank contents; no cs/we in idle cycles; done after 24 cycles.
- Abort after 5 accepts -> state IDLE, bank2 addr0 written only, no done. A new start then reloads bank1 from addr 0.
- start pulsed during LOAD2 -> no effect; the counter and addresses continue unchanged.
- rst_n asserted low during LOAD3 -> all cs/we/in_ready/busy are 0 at once; after release the block sits in IDLE.
- WLOAD_CHECKSUM_EN with words 0xFFFFFFFF x12 -> checksum = 0xFFFFFFF4, checksum_valid = 1 with done.
